// File: rtl/seq_divider_pkg.sv
// Shared constants and FSM state encoding for the sequential signed divider.
// Contents: default operand width, iteration counter width, divider FSM states.
package seq_divider_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between the ALU multdiv slot and the divider.
// master: ctrl_div, data_operandA, data_operandB out; result, remainder, exception, RDY in.
// slave : the mirror image, used by the divider itself.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);

    logic             ctrl_div;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output ctrl_div,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_remainder,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  ctrl_div,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_remainder,
        output data_exception,
        output data_resultRDY
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration (combinational).
// Ports: i_rem      partial remainder before the shift (WIDTH+1 bits)
//        i_bit      next dividend bit shifted into the remainder
//        i_divisor  divisor magnitude
//        o_rem      partial remainder after trial subtract / restore
//        o_qbit     quotient bit produced by this iteration
module div_step
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_sum;

    assign w_shift = {i_rem[WIDTH-1:0], i_bit};

    // Trial subtract as add of the inverted divisor with carry-in 1; carry out = no borrow.
    assign w_sum = {1'b0, w_shift} + {1'b0, ~{1'b0, i_divisor}} + (WIDTH+2)'(1);

    // A set bit shifted out of i_rem means the shifted value already exceeds any divisor.
    assign o_qbit = i_rem[WIDTH] | w_sum[WIDTH+1];
    assign o_rem  = o_qbit ? w_sum[WIDTH:0] : w_shift;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per clock.
// Ports: clock   rising-edge clock
//        resetn  asynchronous active-low reset
//        bus     seq_divider_if.slave: ctrl_div start pulse, operands in;
//                quotient, remainder, exception and one-cycle RDY pulse out.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic         clock,
    input  logic         resetn,
    seq_divider_if.slave bus
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t r_state;
    div_state_t w_next;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_ovf;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_remainder;
    logic             r_exc;
    logic             r_rdy;

    logic             w_load;
    logic             w_zero;
    logic             w_step;
    logic             w_fix;
    logic             w_last;
    logic             w_b_zero;
    logic             w_ovf;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH:0]   w_step_rem;
    logic             w_qbit;

    // Magnitudes as unsigned values so -2^(WIDTH-1) maps to 2^(WIDTH-1).
    assign w_a_abs  = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + WIDTH'(1)) : bus.data_operandA;
    assign w_b_abs  = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + WIDTH'(1)) : bus.data_operandB;
    assign w_b_zero = (bus.data_operandB == '0);
    assign w_ovf    = (bus.data_operandA == MIN_NEG) && (bus.data_operandB == '1);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_quo[WIDTH-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_qbit    (w_qbit)
    );

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_zero = 1'b0;
        w_step = 1'b0;
        w_fix  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_next = ST_IDLE;
                if (bus.ctrl_div) begin
                    if (w_b_zero) begin
                        w_zero = 1'b1;
                        w_next = ST_DONE;
                    end else begin
                        w_load = 1'b1;
                        w_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX: begin
                w_fix  = 1'b1;
                w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand capture and iteration registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_load) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_a_abs;
            r_divisor <= w_b_abs;
            r_sign_q  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            r_sign_r  <= bus.data_operandA[WIDTH-1];
            r_ovf     <= w_ovf;
        end else if (w_step) begin
            r_cnt     <= r_cnt + CNT_W'(1);
            r_rem     <= w_step_rem;
            r_quo     <= {r_quo[WIDTH-2:0], w_qbit};
        end
    end

    // Output registers: written only on sign fix-up or divide-by-zero
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_result    <= '0;
            r_remainder <= '0;
            r_exc       <= 1'b0;
            r_rdy       <= 1'b0;
        end else begin
            r_rdy <= (w_next == ST_DONE);
            if (w_zero) begin
                r_result    <= '0;
                r_remainder <= '0;
                r_exc       <= 1'b1;
            end else if (w_fix) begin
                // Overflow case wraps naturally: magnitude 2^(WIDTH-1), positive sign.
                r_result    <= r_sign_q ? (~r_quo + WIDTH'(1)) : r_quo;
                r_remainder <= r_sign_r ? (~r_rem[WIDTH-1:0] + WIDTH'(1)) : r_rem[WIDTH-1:0];
                r_exc       <= r_ovf;
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_remainder = r_remainder;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;

endmodule
